// File: rtl/vend_pkg.sv
// Shared types and constants for the vending transaction scheduler.
package vend_pkg;

    typedef enum logic [1:0] {IDLE, EXEC, DISP, REFUND} state_t;

    localparam int NUM_REQ = 7;

    // Request vector layout: {clear, refund, buy25, buy15, +50, +10, +5}
    localparam int REQ_COIN5  = 0;
    localparam int REQ_COIN10 = 1;
    localparam int REQ_COIN50 = 2;
    localparam int REQ_BUY15  = 3;
    localparam int REQ_BUY25  = 4;
    localparam int REQ_REFUND = 5;
    localparam int REQ_CLEAR  = 6;

    localparam logic [10:0] COIN5   = 11'd5;
    localparam logic [10:0] COIN10  = 11'd10;
    localparam logic [10:0] COIN50  = 11'd50;
    localparam logic [10:0] PRICE15 = 11'd15;
    localparam logic [10:0] PRICE25 = 11'd25;

    function automatic logic [10:0] coin_value(input logic [NUM_REQ-1:0] g);
        if (g[REQ_COIN50])      return COIN50;
        else if (g[REQ_COIN10]) return COIN10;
        else                    return COIN5;
    endfunction

    function automatic logic [10:0] buy_price(input logic [NUM_REQ-1:0] g);
        return g[REQ_BUY25] ? PRICE25 : PRICE15;
    endfunction

endpackage

// File: rtl/vend_req_arb.sv
// Pending-request register with fixed-priority pick:
// clear > refund > +50 > +10 > +5 > buy25 > buy15.
module vend_req_arb
    import vend_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [NUM_REQ-1:0] req,
    input  logic               take,
    output logic [NUM_REQ-1:0] winner,
    output logic               any
);

    logic [NUM_REQ-1:0] pending;

    always_comb begin
        winner = '0;
        if (pending[REQ_CLEAR])       winner[REQ_CLEAR]  = 1'b1;
        else if (pending[REQ_REFUND]) winner[REQ_REFUND] = 1'b1;
        else if (pending[REQ_COIN50]) winner[REQ_COIN50] = 1'b1;
        else if (pending[REQ_COIN10]) winner[REQ_COIN10] = 1'b1;
        else if (pending[REQ_COIN5])  winner[REQ_COIN5]  = 1'b1;
        else if (pending[REQ_BUY25])  winner[REQ_BUY25]  = 1'b1;
        else if (pending[REQ_BUY15])  winner[REQ_BUY15]  = 1'b1;
    end

    assign any = |pending;

    // New pulses are OR-ed in after the grant clear, so a pulse that
    // coincides with its own grant stays pending for a later pass.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) pending <= '0;
        else     pending <= (pending & ~(take ? winner : '0)) | req;
    end

endmodule

// File: rtl/vend_txn_scheduler.sv
// Vending transaction scheduler: serialises coin/buy/refund/clear requests.
// Define VEND_REFUND_HS_EN to hold refunds in REFUND until refund_ack.
module vend_txn_scheduler
    import vend_pkg::*;
#(
    parameter int MAX_CREDIT = 999,
    parameter int DISP_CYC   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [2:0] coin_req,
    input  logic [1:0] buy_req,
    input  logic       refund_req,
    input  logic       clear_req,
    input  logic       refund_ack,
    output logic [9:0] credit,
    output logic       dispense,
    output logic       refund_valid,
    output logic [9:0] refund_amt,
    output logic       err_low,
    output logic       err_full,
    output logic       busy
);

    localparam int               CNT_W     = (DISP_CYC > 1) ? $clog2(DISP_CYC) : 1;
    localparam logic [10:0]      MAX_C     = 11'(MAX_CREDIT);
    localparam logic [CNT_W-1:0] DISP_LAST = CNT_W'(DISP_CYC - 1);

    state_t             state, state_d;
    logic [NUM_REQ-1:0] grant, grant_d, winner;
    logic               any, take;
    logic [9:0]         credit_q, credit_d;
    logic               err_low_q, err_low_d, err_full_q, err_full_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic [10:0]        sum, diff, price;

    vend_req_arb u_arb (
        .clk    (clk),
        .rst    (rst),
        .req    ({clear_req, refund_req, buy_req, coin_req}),
        .take   (take),
        .winner (winner),
        .any    (any)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            grant      <= '0;
            credit_q   <= '0;
            err_low_q  <= 1'b0;
            err_full_q <= 1'b0;
            cnt        <= '0;
        end else begin
            state      <= state_d;
            grant      <= grant_d;
            credit_q   <= credit_d;
            err_low_q  <= err_low_d;
            err_full_q <= err_full_d;
            cnt        <= cnt_d;
        end
    end

    always_comb begin
        state_d      = state;
        grant_d      = grant;
        credit_d     = credit_q;
        err_low_d    = err_low_q;
        err_full_d   = err_full_q;
        cnt_d        = cnt;
        take         = 1'b0;
        dispense     = 1'b0;
        refund_valid = 1'b0;
        refund_amt   = '0;
        price        = buy_price(grant);
        sum          = {1'b0, credit_q} + coin_value(grant);
        diff         = {1'b0, credit_q} - price;
        case (state)
            IDLE: begin
                if (any) begin
                    take    = 1'b1;
                    grant_d = winner;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                state_d = IDLE;
                if (grant[REQ_CLEAR]) begin
                    credit_d   = '0;
                    err_low_d  = 1'b0;
                    err_full_d = 1'b0;
                end else if (grant[REQ_REFUND]) begin
                    if (credit_q != '0) begin
`ifdef VEND_REFUND_HS_EN
                        state_d = REFUND;
`else
                        refund_valid = 1'b1;
                        refund_amt   = credit_q;
                        credit_d     = '0;
`endif
                    end
                end else if (|grant[REQ_COIN50:REQ_COIN5]) begin
                    if (sum <= MAX_C) begin
                        credit_d   = sum[9:0];
                        err_low_d  = 1'b0;
                        err_full_d = 1'b0;
                    end else begin
                        err_full_d = 1'b1;
                    end
                end else begin
                    if ({1'b0, credit_q} >= price) begin
                        credit_d   = diff[9:0];
                        err_low_d  = 1'b0;
                        err_full_d = 1'b0;
                        cnt_d      = '0;
                        state_d    = DISP;
                    end else begin
                        err_low_d = 1'b1;
                    end
                end
            end
            DISP: begin
                dispense = 1'b1;
                if (cnt == DISP_LAST) state_d = IDLE;
                else                  cnt_d   = cnt + 1'b1;
            end
            REFUND: begin
                // Amount tracks credit, which cannot change while parked here.
                refund_valid = 1'b1;
                refund_amt   = credit_q;
                if (refund_ack) begin
                    credit_d = '0;
                    state_d  = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign credit   = credit_q;
    assign err_low  = err_low_q;
    assign err_full = err_full_q;
    assign busy     = (state != IDLE);

endmodule
